bcd_scan_feeder: RTL and testbench

BCD_SCAN_FEEDER -- requirements
Module: bcd_scan_feeder

---
 rtl/bcd_scan_feeder.sv | 162 ++++++++++++++++
 tb/tb_bcd_scan_feeder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bcd_scan_feeder.sv
// bcd_scan_feeder: converts a 14-bit binary value to four BCD digits with a
// sequential double-dabble. The value saturates to 9999 when it is out of range.
// The published digits are held steady for a downstream multiplexed
// seven-segment scan stage. A free-running refresh counter supplies that
// stage's digit-select count.
module bcd_scan_feeder #(
  parameter int SCAN_DIV_BITS = 18
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [13:0] bin_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic [3:0] SSD3,
  output logic [3:0] SSD2,
  output logic [3:0] SSD1,
  output logic [3:0] SSD0,
  output logic [1:0] ssdscan_clk
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam logic [3:0]  SHIFT_COUNT = 4'd14;
  localparam logic [13:0] MAX_DISP    = 14'd9999;
  localparam logic [SCAN_DIV_BITS-1:0] REFRESH_ONE =
    {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};

  state_t      state_q;
  state_t      state_d;
  logic        capture;
  logic        shift_en;
  logic        publish;

  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt_q;
  logic        ovf_q;
  logic [15:0] dig_q;
  logic        ovf_out_q;
  logic        busy_q;
  logic        done_q;
  logic [SCAN_DIV_BITS-1:0] refresh_q;

  // Adds 3 to every nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Clamps the display to 9999 when the captured value did not fit in four digits.
  function automatic logic [15:0] saturate_bcd(input logic [15:0] bcd, input logic ovf);
    return ovf ? 16'h9999 : bcd;
  endfunction

  assign bcd_adj = dabble_adjust(bcd_q);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    shift_en = 1'b0;
    publish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == 4'd1)
          state_d = PUBLISH;
      end
      PUBLISH: begin
        publish = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion work registers: capture, then one double-dabble step per SHIFT cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (capture) begin
      bin_q <= bin_in;
      bcd_q <= '0;
      cnt_q <= SHIFT_COUNT;
      ovf_q <= (bin_in > MAX_DISP);
    end else if (shift_en) begin
      bcd_q <= {bcd_adj[14:0], bin_q[13]};
      bin_q <= {bin_q[12:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Published digits and overflow flag: updated together, only on PUBLISH
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dig_q     <= '0;
      ovf_out_q <= 1'b0;
    end else if (publish) begin
      dig_q     <= saturate_bcd(bcd_q, ovf_q);
      ovf_out_q <= ovf_q;
    end
  end

  // Handshake outputs: busy covers the shift cycles plus the done cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_q == SHIFT) || (state_q == PUBLISH);
      done_q <= (state_q == PUBLISH);
    end
  end

  // Free-running refresh counter for the scan stage, independent of the FSM
  always_ff @(posedge Clk) begin
    if (Reset)
      refresh_q <= '0;
    else
      refresh_q <= refresh_q + REFRESH_ONE;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_out_q;
  assign SSD3        = dig_q[15:12];
  assign SSD2        = dig_q[11:8];
  assign SSD1        = dig_q[7:4];
  assign SSD0        = dig_q[3:0];
  assign ssdscan_clk = refresh_q[SCAN_DIV_BITS-1 -: 2];

endmodule

// File: tb/tb_bcd_scan_feeder.sv
// Testbench for bcd_scan_feeder: directed and random conversions checked
// against an arithmetic reference model of the display contents and scan count.
module tb_bcd_scan_feeder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [13:0] bin_in;
  logic        load;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  SSD3, SSD2, SSD1, SSD0;
  logic [1:0]  ssdscan_clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          ref_cyc = 0;
  logic [15:0] exp_dig = '0;
  logic        exp_ovf = 1'b0;

  bcd_scan_feeder #(.SCAN_DIV_BITS(4)) dut (
    .Clk(Clk), .Reset(Reset), .bin_in(bin_in), .load(load),
    .busy(busy), .done(done), .overflow(overflow),
    .SSD3(SSD3), .SSD2(SSD2), .SSD1(SSD1), .SSD0(SSD0),
    .ssdscan_clk(ssdscan_clk)
  );

  always #5 Clk = ~Clk;

  // Edges elapsed since the last reset edge
  always @(posedge Clk) begin
    if (Reset) ref_cyc <= 0;
    else       ref_cyc <= ref_cyc + 1;
  end

  function automatic logic [15:0] model_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [1:0] model_scan(input int c);
    return 2'((c % 16) / 4);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input logic exp_busy, input logic exp_done);
    chk("busy", {15'd0, busy}, {15'd0, exp_busy});
    chk("done", {15'd0, done}, {15'd0, exp_done});
    chk("digits", {SSD3, SSD2, SSD1, SSD0}, exp_dig);
    chk("overflow", {15'd0, overflow}, {15'd0, exp_ovf});
    chk("scan", {14'd0, ssdscan_clk}, {14'd0, model_scan(ref_cyc)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      load = 1'b0;
      bin_in = 14'($urandom);
      @(posedge Clk); #1;
      chk_all(1'b0, 1'b0);
    end
  endtask

  // One conversion; optionally pokes load with 777 at k+3 and k+15, or resets at k+abort_at
  task automatic run_conv(input int v, input bit intrude, input int abort_at);
    @(negedge Clk);
    bin_in = 14'(v);
    load = 1'b1;
    @(posedge Clk); #1;
    chk_all(1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge Clk);
      load = intrude && (i == 3 || i == 15);
      bin_in = load ? 14'd777 : 14'($urandom);
      if (i == abort_at) Reset = 1'b1;
      @(posedge Clk); #1;
      if (i == abort_at) begin
        exp_dig = '0;
        exp_ovf = 1'b0;
        chk_all(1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        load = 1'b0;
        return;
      end
      if (i == 15) begin
        exp_dig = model_bcd(v);
        exp_ovf = (v > 9999);
      end
      chk_all(1'b1, i == 15);
    end
  endtask

  initial begin
    Reset = 1'b1;
    load = 1'b1;
    bin_in = 14'd1234;
    repeat (3) @(posedge Clk);
    #1;
    chk_all(1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    load = 1'b0;
    // Load during reset ignored; 20 idle cycles watch the scan count wrap
    idle(20);

    run_conv(1234, 1'b0, 0);
    idle(1);
    run_conv(9999, 1'b0, 0);
    run_conv(0, 1'b0, 0);
    run_conv(10000, 1'b0, 0);
    run_conv(16383, 1'b0, 0);
    idle(2);

    run_conv(42, 1'b1, 0);
    run_conv(100, 1'b0, 0);
    idle(1);

    run_conv(5678, 1'b0, 0);
    run_conv(1111, 1'b0, 7);
    run_conv(321, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      int v;
      v = (n % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 16383));
      run_conv(v, 1'b0, 0);
      idle(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
